// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and instruction memory (slave).
// One word read per req/ack handshake; mem_err is qualified by mem_ack.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: issues one word read per pc, holds the returned word until taken, flags faults.
// Optional request timeout is enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] FAULT_INST     = 32'h0000_0000
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        inst_taken,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_fault,
  inst_fetch_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID
  } state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic        drop;
  logic        ack_eff;
  logic        err_eff;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] timer;
  logic          stale;
  logic          ack_real;
  logic          expired;

  // timer holds completed REQ cycles, so expiry lands on the TIMEOUT_CYCLES-th REQ cycle.
  // stale swallows the one late ack belonging to a timed-out request.
  always_comb begin
    ack_real = mem.mem_ack && !stale;
    expired  = (state == REQ) && (timer == TW'(TIMEOUT_CYCLES - 1));
    ack_eff  = ack_real || expired;
    err_eff  = ack_real ? mem.mem_err : 1'b1;
  end
`else
  always_comb begin
    ack_eff = mem.mem_ack;
    err_eff = mem.mem_err;
  end
`endif

  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      state        <= IDLE;
      inst         <= FAULT_INST;
      inst_pc      <= '0;
      inst_valid   <= 1'b0;
      fetch_fault  <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      drop         <= 1'b0;
      req_pc       <= '0;
`ifdef FETCH_TIMEOUT_EN
      timer        <= '0;
      stale        <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      if (mem.mem_ack && stale) stale <= 1'b0;
      if (state == REQ) timer <= timer + 1'b1;
`endif
      unique case (state)
        IDLE: begin
          req_pc <= pc;
          if (pc[1:0] != 2'b00) begin
            inst        <= FAULT_INST;
            inst_pc     <= pc;
            fetch_fault <= 1'b1;
            inst_valid  <= 1'b1;
            state       <= VALID;
          end else begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= {pc[31:2], 2'b00};
`ifdef FETCH_TIMEOUT_EN
            timer        <= '0;
`endif
            state        <= REQ;
          end
        end

        REQ: begin
          if (ack_eff) begin
            mem.mem_req <= 1'b0;
            // A flush arriving with the ack discards the word just like an earlier one.
            if (drop || flush) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              inst        <= err_eff ? FAULT_INST : mem.mem_rdata;
              fetch_fault <= err_eff;
              inst_pc     <= req_pc;
              inst_valid  <= 1'b1;
              state       <= VALID;
            end
`ifdef FETCH_TIMEOUT_EN
            if (expired && !ack_real) stale <= 1'b1;
`endif
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        VALID: begin
          if (inst_taken || flush) begin
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
